// File: rtl/serdesphy_pkg.sv
// Shared types and constants for the SerDes PHY link sequencer: state encoding,
// error cause codes, retry policy and the per-state control decode.
package serdesphy_pkg;

    typedef enum logic [3:0] {
        ST_OFF        = 4'd0,
        ST_ISO_REL    = 4'd1,
        ST_PLL_RST    = 4'd2,
        ST_PLL_WAIT   = 4'd3,
        ST_CDR_WAIT   = 4'd4,
        ST_ALIGN_WAIT = 4'd5,
        ST_READY      = 4'd6,
        ST_ERROR      = 4'd7
    } seq_state_e;

    localparam logic [1:0] ERR_NONE       = 2'd0;
    localparam logic [1:0] ERR_PLL_TO     = 2'd1;
    localparam logic [1:0] ERR_CDR_TO     = 2'd2;
    localparam logic [1:0] ERR_ALIGN_LOST = 2'd3;

    localparam logic [1:0] RETRY_LIMIT   = 2'd3;
    localparam int         RETRY_BACKOFF = 256;

    typedef struct packed {
        logic iso_en;
        logic pll_rst;
        logic tx_en;
        logic rx_en;
        logic cdr_rst;
        logic rx_align_rst;
        logic phy_ready;
    } seq_ctl_t;

    // OFF and ERROR share the fully-safe default; a resync visit to CDR_WAIT
    // holds the CDR in reset instead of releasing it.
    function automatic seq_ctl_t ctl_decode(input seq_state_e s, input logic resync);
        seq_ctl_t c;
        c = '{iso_en: 1'b1, pll_rst: 1'b1, tx_en: 1'b0, rx_en: 1'b0,
              cdr_rst: 1'b1, rx_align_rst: 1'b1, phy_ready: 1'b0};
        case (s)
            ST_ISO_REL, ST_PLL_RST: begin
                c.iso_en = 1'b0;
            end
            ST_PLL_WAIT: begin
                c.iso_en  = 1'b0;
                c.pll_rst = 1'b0;
            end
            ST_CDR_WAIT: begin
                c.iso_en  = 1'b0;
                c.pll_rst = 1'b0;
                c.tx_en   = 1'b1;
                c.rx_en   = 1'b1;
                c.cdr_rst = resync;
            end
            ST_ALIGN_WAIT, ST_READY: begin
                c.iso_en       = 1'b0;
                c.pll_rst      = 1'b0;
                c.tx_en        = 1'b1;
                c.rx_en        = 1'b1;
                c.cdr_rst      = 1'b0;
                c.rx_align_rst = 1'b0;
                c.phy_ready    = (s == ST_READY);
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/serdesphy_seq_timer.sv
// Loadable up-counter with synchronous clear and a terminal-count match flag,
// used as the per-state delay/timeout timer of the link sequencer.
module serdesphy_seq_timer #(
    parameter int CNT_W = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic [CNT_W-1:0] i_match_val,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_match
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt   = r_cnt;
    assign o_match = (r_cnt == i_match_val);

endmodule

// File: rtl/serdesphy_link_seq.sv
// SerDes PHY link bring-up / recovery sequencer (24 MHz reference domain).
// Optional SERDESPHY_LINK_SEQ_RETRY_EN: ERROR backs off and retries from PLL_RST.
module serdesphy_link_seq
    import serdesphy_pkg::*;
#(
    parameter int ISO_DLY     = 16,
    parameter int PLL_RST_CYC = 24,
    parameter int PLL_LOCK_TO = 4096,
    parameter int CDR_LOCK_TO = 8192,
    parameter int ALIGN_TO    = 2048,
    parameter int CNT_W       = 14
) (
    input  logic       clk_ref_24m,
    input  logic       rst,
    input  logic       phy_en,
    input  logic       dvdd_ok,
    input  logic       avdd_ok,
    input  logic       pll_lock,
    input  logic       cdr_lock,
    input  logic       rx_aligned,
    output logic       iso_en,
    output logic       pll_rst,
    output logic       tx_en,
    output logic       rx_en,
    output logic       cdr_rst,
    output logic       rx_align_rst,
    output logic       phy_ready,
    output logic [3:0] seq_state,
    output logic       seq_error,
    output logic [1:0] err_code
`ifdef SERDESPHY_LINK_SEQ_RETRY_EN
    ,
    output logic [1:0] retry_cnt
`endif
);

    seq_state_e       r_state, w_next;
    logic [1:0]       w_cause;
    logic             w_pwr_ok;
    logic             w_last;
    logic             w_tmr_en;
    logic [CNT_W-1:0] w_limit;
    logic [CNT_W-1:0] w_cnt;
    logic             r_resync;
    logic             r_err;
    logic [1:0]       r_code;
    seq_ctl_t         w_ctl;
`ifdef SERDESPHY_LINK_SEQ_RETRY_EN
    logic [1:0]       r_retry;
`endif

    assign w_pwr_ok = phy_en & dvdd_ok & avdd_ok;

    always_comb begin
        w_limit  = '1;
        w_tmr_en = 1'b1;
        case (r_state)
            ST_ISO_REL:    w_limit = CNT_W'(ISO_DLY - 1);
            ST_PLL_RST:    w_limit = CNT_W'(PLL_RST_CYC - 1);
            ST_PLL_WAIT:   w_limit = CNT_W'(PLL_LOCK_TO - 1);
            ST_CDR_WAIT:   w_limit = CNT_W'(CDR_LOCK_TO - 1);
            ST_ALIGN_WAIT: w_limit = CNT_W'(ALIGN_TO - 1);
            ST_ERROR:      w_limit = CNT_W'(RETRY_BACKOFF - 1);
            default:       w_tmr_en = 1'b0;
        endcase
    end

    serdesphy_seq_timer #(.CNT_W(CNT_W)) u_timer (
        .clk         (clk_ref_24m),
        .rst         (rst),
        .i_clr       (w_next != r_state),
        .i_en        (w_tmr_en),
        .i_load      (1'b0),
        .i_load_val  ('0),
        .i_match_val (w_limit),
        .o_cnt       (w_cnt),
        .o_match     (w_last)
    );

    always_ff @(posedge clk_ref_24m) begin
        if (rst) begin
            r_state <= ST_OFF;
        end else begin
            r_state <= w_next;
        end
    end

    // Power loss beats everything; PLL lock loss beats CDR/align events; a lock beats its timeout.
    always_comb begin
        w_next  = r_state;
        w_cause = ERR_NONE;
        if (!w_pwr_ok) begin
            w_next = ST_OFF;
        end else begin
            case (r_state)
                ST_OFF:     w_next = ST_ISO_REL;
                ST_ISO_REL: if (w_last) w_next = ST_PLL_RST;
                ST_PLL_RST: if (w_last) w_next = ST_PLL_WAIT;
                ST_PLL_WAIT: begin
                    if (pll_lock) begin
                        w_next = ST_CDR_WAIT;
                    end else if (w_last) begin
                        w_next  = ST_ERROR;
                        w_cause = ERR_PLL_TO;
                    end
                end
                ST_CDR_WAIT: begin
                    if (!pll_lock) begin
                        w_next  = ST_ERROR;
                        w_cause = ERR_ALIGN_LOST;
                    end else if (cdr_lock) begin
                        w_next = ST_ALIGN_WAIT;
                    end else if (w_last) begin
                        w_next  = ST_ERROR;
                        w_cause = ERR_CDR_TO;
                    end
                end
                ST_ALIGN_WAIT: begin
                    if (!pll_lock || (!rx_aligned && w_last)) begin
                        w_next  = ST_ERROR;
                        w_cause = ERR_ALIGN_LOST;
                    end else if (rx_aligned) begin
                        w_next = ST_READY;
                    end
                end
                ST_READY: begin
                    if (!pll_lock) begin
                        w_next  = ST_ERROR;
                        w_cause = ERR_ALIGN_LOST;
                    end else if (!cdr_lock) begin
                        w_next = ST_CDR_WAIT;
                    end else if (!rx_aligned) begin
                        w_next = ST_ALIGN_WAIT;
                    end
                end
                ST_ERROR: begin
`ifdef SERDESPHY_LINK_SEQ_RETRY_EN
                    if (w_last && (r_retry != RETRY_LIMIT)) w_next = ST_PLL_RST;
`endif
                end
                default: w_next = ST_OFF;
            endcase
        end
    end

    always_comb begin
        w_ctl = ctl_decode(r_state, r_resync);
    end

    assign iso_en       = w_ctl.iso_en;
    assign pll_rst      = w_ctl.pll_rst;
    assign tx_en        = w_ctl.tx_en;
    assign rx_en        = w_ctl.rx_en;
    assign cdr_rst      = w_ctl.cdr_rst;
    assign rx_align_rst = w_ctl.rx_align_rst;
    assign phy_ready    = w_ctl.phy_ready;
    assign seq_state    = r_state;
    assign seq_error    = r_err;
    assign err_code     = r_code;

    // Marks a CDR_WAIT visit entered from READY, held for the whole visit.
    always_ff @(posedge clk_ref_24m) begin
        if (rst) begin
            r_resync <= 1'b0;
        end else begin
            r_resync <= (w_next == ST_CDR_WAIT) &&
                        ((r_state == ST_READY) || ((r_state == ST_CDR_WAIT) && r_resync));
        end
    end

    always_ff @(posedge clk_ref_24m) begin
        if (rst) begin
            r_err  <= 1'b0;
            r_code <= ERR_NONE;
        end else if ((w_next == ST_OFF) && (r_state != ST_OFF)) begin
            r_err  <= 1'b0;
            r_code <= ERR_NONE;
        end else if ((w_next == ST_ERROR) && (r_state != ST_ERROR)) begin
            r_code <= w_cause;
`ifdef SERDESPHY_LINK_SEQ_RETRY_EN
            r_err  <= (r_retry == RETRY_LIMIT);
`else
            r_err  <= 1'b1;
`endif
        end
    end

`ifdef SERDESPHY_LINK_SEQ_RETRY_EN
    always_ff @(posedge clk_ref_24m) begin
        if (rst) begin
            r_retry <= '0;
        end else if (((w_next == ST_OFF) && (r_state != ST_OFF)) ||
                     ((w_next == ST_READY) && (r_state != ST_READY))) begin
            r_retry <= '0;
        end else if ((r_state == ST_ERROR) && (w_next == ST_PLL_RST)) begin
            r_retry <= r_retry + 2'd1;
        end
    end

    assign retry_cnt = r_retry;
`endif

endmodule

// File: tb/tb_serdesphy_link_seq.sv
// Self-checking bench for serdesphy_link_seq: directed bring-up/fault scenarios
// plus randomized input segments, all checked against a behavioural model.
module tb_serdesphy_link_seq;

    localparam int S_OFF = 0, S_ISO = 1, S_PRST = 2, S_PWAIT = 3;
    localparam int S_CWAIT = 4, S_AWAIT = 5, S_READY = 6, S_ERR = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic phy_en = 1'b0, dvdd_ok = 1'b0, avdd_ok = 1'b0;
    logic pll_lock = 1'b0, cdr_lock = 1'b0, rx_aligned = 1'b0;
    logic iso_en, pll_rst, tx_en, rx_en, cdr_rst, rx_align_rst, phy_ready;
    logic [3:0] seq_state;
    logic       seq_error;
    logic [1:0] err_code;
`ifdef SERDESPHY_LINK_SEQ_RETRY_EN
    logic [1:0] retry_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // model state: phase, cycles spent in it, sticky error, cause, resync visit, retries
    int m_st = S_OFF, m_age = 0, m_code = 0, m_retry = 0;
    bit m_err = 1'b0, m_rsync = 1'b0;
    int hold[6];

    serdesphy_link_seq #(
        .ISO_DLY(4), .PLL_RST_CYC(4), .PLL_LOCK_TO(64), .CDR_LOCK_TO(64), .ALIGN_TO(64)
    ) dut (
        .clk_ref_24m (clk),
        .rst         (rst),
        .phy_en      (phy_en),
        .dvdd_ok     (dvdd_ok),
        .avdd_ok     (avdd_ok),
        .pll_lock    (pll_lock),
        .cdr_lock    (cdr_lock),
        .rx_aligned  (rx_aligned),
        .iso_en      (iso_en),
        .pll_rst     (pll_rst),
        .tx_en       (tx_en),
        .rx_en       (rx_en),
        .cdr_rst     (cdr_rst),
        .rx_align_rst(rx_align_rst),
        .phy_ready   (phy_ready),
        .seq_state   (seq_state),
        .seq_error   (seq_error),
        .err_code    (err_code)
`ifdef SERDESPHY_LINK_SEQ_RETRY_EN
        ,
        .retry_cnt   (retry_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Duration in cycles of each timed phase; 0 means the phase never times out.
    function automatic int dur(input int st);
        case (st)
            S_ISO, S_PRST:           return 4;
            S_PWAIT, S_CWAIT, S_AWAIT: return 64;
            S_ERR:                   return 256;
            default:                 return 0;
        endcase
    endfunction

    // {iso_en, pll_rst, tx_en, rx_en, cdr_rst, rx_align_rst, phy_ready}
    function automatic logic [6:0] m_ctl();
        case (m_st)
            S_ISO, S_PRST: return 7'b0100110;
            S_PWAIT:       return 7'b0000110;
            S_CWAIT:       return m_rsync ? 7'b0011110 : 7'b0011010;
            S_AWAIT:       return 7'b0011000;
            S_READY:       return 7'b0011001;
            default:       return 7'b1100110;
        endcase
    endfunction

    task automatic model_step();
        int  nx, cause;
        bit  pw, expired;
        if (rst) begin
            m_st = S_OFF; m_age = 0; m_err = 0; m_code = 0; m_rsync = 0; m_retry = 0;
            return;
        end
        pw      = phy_en && dvdd_ok && avdd_ok;
        expired = (dur(m_st) != 0) && (m_age + 1 == dur(m_st));
        nx      = m_st;
        cause   = 0;
        if (!pw) nx = S_OFF;
        else begin
            case (m_st)
                S_OFF:   nx = S_ISO;
                S_ISO:   if (expired) nx = S_PRST;
                S_PRST:  if (expired) nx = S_PWAIT;
                S_PWAIT: if (pll_lock) nx = S_CWAIT; else if (expired) begin nx = S_ERR; cause = 1; end
                S_CWAIT: if (!pll_lock) begin nx = S_ERR; cause = 3; end
                         else if (cdr_lock) nx = S_AWAIT;
                         else if (expired) begin nx = S_ERR; cause = 2; end
                S_AWAIT: if (!pll_lock) begin nx = S_ERR; cause = 3; end
                         else if (rx_aligned) nx = S_READY;
                         else if (expired) begin nx = S_ERR; cause = 3; end
                S_READY: if (!pll_lock) begin nx = S_ERR; cause = 3; end
                         else if (!cdr_lock) nx = S_CWAIT;
                         else if (!rx_aligned) nx = S_AWAIT;
                default: begin
`ifdef SERDESPHY_LINK_SEQ_RETRY_EN
                    if (expired && m_retry < 3) nx = S_PRST;
`endif
                end
            endcase
        end
        if (nx == S_OFF && m_st != S_OFF) begin
            m_err = 0; m_code = 0; m_retry = 0;
        end
        if (nx == S_ERR && m_st != S_ERR) begin
            m_code = cause;
`ifdef SERDESPHY_LINK_SEQ_RETRY_EN
            m_err = (m_retry == 3);
`else
            m_err = 1;
`endif
        end
        if (m_st == S_ERR && nx == S_PRST) m_retry++;
        if (nx == S_READY && m_st != S_READY) m_retry = 0;
        m_rsync = (nx == S_CWAIT) && (m_st == S_READY || (m_st == S_CWAIT && m_rsync));
        m_age   = (nx != m_st) ? 0 : m_age + 1;
        m_st    = nx;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        chk("lockstep", {iso_en, pll_rst, tx_en, rx_en, cdr_rst, rx_align_rst, phy_ready,
                         seq_state, seq_error, err_code},
                        {m_ctl(), 4'(m_st), m_err, 2'(m_code)});
`ifdef SERDESPHY_LINK_SEQ_RETRY_EN
        chk("retry_lockstep", retry_cnt, m_retry);
`endif
    endtask

    task automatic set_pwr(input logic v);
        phy_en = v; dvdd_ok = v; avdd_ok = v;
    endtask

    task automatic go_off();
        set_pwr(1'b0);
        pll_lock = 0; cdr_lock = 0; rx_aligned = 0;
        step();
        chk("off_state", seq_state, S_OFF);
        chk("off_err_clr", {seq_error, err_code}, 0);
    endtask

    task automatic bring_to_pll_wait();
        set_pwr(1'b1);
        pll_lock = 0; cdr_lock = 0; rx_aligned = 0;
        repeat (9) step();
        chk("pll_wait_entry", seq_state, S_PWAIT);
    endtask

    task automatic wait_state(input string tag, input int st, input int budget, output int cyc);
        cyc = 0;
        while (seq_state != st && cyc < budget) begin
            step();
            cyc++;
        end
        chk(tag, seq_state, st);
    endtask

    task automatic rnd_drive();
        for (int k = 0; k < 6; k++) begin
            if (hold[k] == 0) begin
                logic v;
                v = ($urandom_range(99) < ((k < 3) ? 97 : 80));
                hold[k] = (k < 3) ? $urandom_range(300, 20) : $urandom_range(120, 1);
                case (k)
                    0: phy_en = v;
                    1: dvdd_ok = v;
                    2: avdd_ok = v;
                    3: pll_lock = v;
                    4: cdr_lock = v;
                    default: rx_aligned = v;
                endcase
            end else begin
                hold[k]--;
            end
        end
        rst = ($urandom_range(999) == 0);
    endtask

    initial begin
        int prst_hi, c;

        // reset
        rst = 1'b1;
        repeat (3) step();
        chk("reset_state", {seq_state, seq_error, err_code}, 0);
        chk("reset_iso", iso_en, 1);
        rst = 1'b0;

        // nominal bring-up: PLL_WAIT entered at edge 9
        set_pwr(1'b1);
        step();
        chk("iso_fall", iso_en, 0);
        chk("iso_rel_state", seq_state, S_ISO);
        prst_hi = 0;
        for (int n = 2; n <= 27; n++) begin
            if (n == 19) pll_lock = 1;
            if (n == 24) cdr_lock = 1;
            if (n == 27) rx_aligned = 1;
            step();
            if (seq_state == S_PRST && pll_rst) prst_hi++;
        end
        chk("pll_rst_len", prst_hi, 4);
        chk("ready_at_27", phy_ready, 1);
        chk("ready_state", seq_state, S_READY);

        // one-cycle CDR lock loss in READY
        cdr_lock = 0;
        step();
        chk("resync_state", seq_state, S_CWAIT);
        chk("resync_notready", phy_ready, 0);
        chk("resync_cdr_rst", cdr_rst, 1);
        cdr_lock = 1;
        repeat (2) step();
        chk("relock_ready", seq_state, S_READY);
        chk("relock_noerr", seq_error, 0);

        // PLL and CDR lock lost together in READY
        pll_lock = 0; cdr_lock = 0;
        step();
        chk("simul_state", seq_state, S_ERR);
        chk("simul_code", err_code, 3);
`ifdef SERDESPHY_LINK_SEQ_RETRY_EN
        chk("simul_flag", seq_error, 0);
`else
        chk("simul_flag", seq_error, 1);
`endif
        go_off();

        // PLL lock timeout exactly 64 cycles after PLL_WAIT entry
        bring_to_pll_wait();
        repeat (63) step();
        chk("pll_to_before", seq_state, S_PWAIT);
        step();
        chk("pll_to_state", seq_state, S_ERR);
        chk("pll_to_code", err_code, 1);
        chk("pll_to_iso", iso_en, 1);
`ifndef SERDESPHY_LINK_SEQ_RETRY_EN
        chk("pll_to_flag", seq_error, 1);
`endif
        go_off();

        // supply drop coincident with the timeout edge
        bring_to_pll_wait();
        repeat (63) step();
        avdd_ok = 0;
        step();
        chk("avdd_vs_to_state", seq_state, S_OFF);
        chk("avdd_vs_to_err", {seq_error, err_code}, 0);

        // lock on the last allowed cycle wins over the timeout
        bring_to_pll_wait();
        repeat (63) step();
        pll_lock = 1;
        step();
        chk("lock_at_edge", seq_state, S_CWAIT);
        chk("lock_at_edge_err", seq_error, 0);
        go_off();

        // lock one cycle late is too late
        bring_to_pll_wait();
        repeat (64) step();
        chk("lock_late_err", seq_state, S_ERR);
        pll_lock = 1;
        step();
        chk("lock_late_stays", seq_state, S_ERR);
        go_off();

`ifdef SERDESPHY_LINK_SEQ_RETRY_EN
        // stuck PLL: three retries, then terminal error
        bring_to_pll_wait();
        repeat (64) step();
        chk("retry0_state", seq_state, S_ERR);
        chk("retry0_cnt", retry_cnt, 0);
        chk("retry0_flag", seq_error, 0);
        for (int r = 1; r <= 3; r++) begin
            wait_state("retry_restart", S_PRST, 300, c);
            chk("retry_backoff", c, 256);
            chk("retry_cnt", retry_cnt, r);
            wait_state("retry_fail", S_ERR, 100, c);
            chk("retry_fail_len", c, 68);
        end
        chk("retry_exhausted_flag", seq_error, 1);
        chk("retry_exhausted_code", err_code, 1);
        repeat (300) step();
        chk("retry_terminal", seq_state, S_ERR);
        go_off();

        // lock during second retry recovers and clears the counter
        bring_to_pll_wait();
        repeat (64) step();
        wait_state("r2_restart1", S_PRST, 300, c);
        wait_state("r2_fail1", S_ERR, 100, c);
        wait_state("r2_restart2", S_PRST, 300, c);
        chk("r2_cnt", retry_cnt, 2);
        pll_lock = 1; cdr_lock = 1; rx_aligned = 1;
        wait_state("r2_ready", S_READY, 20, c);
        chk("r2_cnt_clr", retry_cnt, 0);
        chk("r2_flag", seq_error, 0);
        go_off();
`endif

        // randomized segments
        for (int k = 0; k < 6; k++) hold[k] = 0;
        for (int n = 0; n < 4000; n++) begin
            rnd_drive();
            step();
        end
        rst = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serdesphy_link_seq.md
Name: serdesphy_link_seq

Overview:
Link bring-up and recovery sequencer for the SerDes PHY, in the 24 MHz reference domain beside the PCS control logic.
- Power-up flow: power-good, analog isolation release, PLL reset, PLL lock, TX/RX enable, CDR lock, RX alignment, phy_ready.
- Drives the iso_en / pll_rst / tx_en / rx_en / cdr_rst / rx_align_rst controls that CSRs otherwise hold static.
- Supervises lock loss during operation.

Parameters:
- ISO_DLY, 16, cycles held in ISO_REL before PLL reset.
- PLL_RST_CYC, 24, cycles pll_rst stays asserted in PLL_RST.
- PLL_LOCK_TO, 4096, max cycles waiting for pll_lock.
- CDR_LOCK_TO, 8192, max cycles waiting for cdr_lock.
- ALIGN_TO, 2048, max cycles waiting for rx_aligned.
- CNT_W, 14, timer width; must hold the largest parameter.

Ports:
- clk_ref_24m  in  1  reference clock, sole clock.
- rst  in  1  synchronous active-high reset.
- phy_en  in  1  enable from CSR.
- dvdd_ok  in  1  digital supply good.
- avdd_ok  in  1  analog supply good.
- pll_lock  in  1  PLL lock status (already synchronised).
- cdr_lock  in  1  CDR lock status (already synchronised).
- rx_aligned  in  1  RX word alignment achieved.
- iso_en  out  1  analog isolation.
- pll_rst  out  1  PLL reset.
- tx_en  out  1  serializer enable.
- rx_en  out  1  deserializer enable.
- cdr_rst  out  1  CDR reset.
- rx_align_rst  out  1  aligner reset.
- phy_ready  out  1  link up.
- seq_state  out  4  current state encoding.
- seq_error  out  1  sticky error flag.
- err_code  out  2  cause: 1 PLL timeout, 2 CDR timeout, 3 align timeout / PLL lock lost.

Behaviour:
State machine and outputs:
- States, in encoding order 0..7: OFF, ISO_REL, PLL_RST, PLL_WAIT, CDR_WAIT, ALIGN_WAIT, READY, ERROR.
- All outputs are Moore decodes of the state register, so they change on the same edge as the state.
- Define pwr_ok = phy_en & dvdd_ok & avdd_ok.
- Reset: state OFF, timer 0, seq_error 0, err_code 0.
- OFF outputs: iso_en=1, pll_rst=1, tx_en=0, rx_en=0, cdr_rst=1, rx_align_rst=1, phy_ready=0.
- ERROR drives the same outputs as OFF.

Transitions:
- OFF -> ISO_REL when pwr_ok. iso_en=0 from ISO_REL onward.
- ISO_REL: after ISO_DLY cycles -> PLL_RST.
- PLL_RST: pll_rst=1 for PLL_RST_CYC cycles -> PLL_WAIT. pll_rst=0 from PLL_WAIT onward.
- PLL_WAIT: on pll_lock=1 -> CDR_WAIT. After PLL_LOCK_TO cycles without lock -> ERROR, err_code=1.
- CDR_WAIT: tx_en=1, rx_en=1, cdr_rst=0. On cdr_lock -> ALIGN_WAIT. On timeout -> ERROR, err_code=2.
- ALIGN_WAIT: rx_align_rst=0. On rx_aligned -> READY. On timeout -> ERROR, err_code=3.
- READY: phy_ready=1.
  - cdr_lock=0 -> CDR_WAIT. This is a resync, not an error: cdr_rst and rx_align_rst reassert for that state.
  - rx_aligned=0 with cdr_lock=1 -> ALIGN_WAIT.
- ERROR: latches seq_error=1; stays until pwr_ok=0.

Timer:
- Cleared on every state entry; increments each cycle in timed states.
- Delay/timeout fires when timer == PARAM-1. A state with PARAM=N lasts exactly N cycles.

Priorities:
- pwr_ok=0 in any state -> OFF on the next edge. This overrides everything, including timeout and lock events in the same cycle.
- seq_error and err_code clear only on entry to OFF.
- In CDR_WAIT through READY, pll_lock=0 -> ERROR, err_code=3 (lock lost). This takes priority over cdr_lock and rx_aligned events in the same cycle.
- Lock arriving in the same cycle as a timeout: the lock wins.
- rst mid-sequence -> OFF on that edge.

Optional Feature:
- Macro: SERDESPHY_LINK_SEQ_RETRY_EN.
- Defined:
  - ERROR auto-restarts to PLL_RST after 256 cycles, up to 3 retries.
  - 2-bit retry counter, cleared on OFF entry and on reaching READY.
  - seq_error asserts only once retries are exhausted. err_code always records the latest cause.
  - Extra output port retry_cnt [1:0].
- Undefined: ERROR is terminal until pwr_ok drops; there is no retry_cnt port.

Decomposition:
- Shared package serdesphy_pkg holds:
  - the state enum (4-bit);
  - err_code constants ERR_NONE, ERR_PLL_TO, ERR_CDR_TO, ERR_ALIGN_LOST;
  - the retry limit and backoff constant.
- One natural sub-module: serdesphy_seq_timer, a loadable up-counter with clear and match compare for terminal count.

Test Plan:
- Nominal bring-up, params overridden to 4/4/64/64/64. rst, pwr_ok=1; pll_lock at PLL_WAIT+10, cdr_lock +5, rx_aligned +3.
  - iso_en falls 1 cycle after pwr_ok.
  - pll_rst is high exactly 4 cycles in PLL_RST.
  - phy_ready=1 at the expected cycle; seq_state=6.
- PLL timeout: pll_lock held 0.
  - ERROR exactly 64 cycles after PLL_WAIT entry; err_code=1, seq_error=1, iso_en=1.
  - phy_en=0 -> OFF with error cleared.
- CDR loss in READY: drop cdr_lock 1 cycle.
  - Next state CDR_WAIT, phy_ready=0, cdr_rst=1 for that state.
  - Relock returns to READY with no error.
- Simultaneous events: pll_lock=0 and cdr_lock=0 in the same READY cycle -> ERROR, err_code=3.
  - Separately, avdd_ok=0 together with a timeout -> OFF, seq_error=0.
- Boundary: lock at timer=PARAM-1 -> advances, no error. Lock one cycle later -> ERROR.
- Retry (macro on): pll_lock stuck 0.
  - retry_cnt 1,2,3 observed; seq_error=1 after the 4th timeout.
  - pll_lock=1 during retry 2 -> READY, retry_cnt=0.
